// File: rtl/fifo_sync_lvl_pkg.sv
// Shared helpers for the fifo_sync_lvl family: width functions and read-mode constants.
package fifo_pkg;

  localparam int MODE_SHOW_AHEAD = 1;
  localparam int MODE_REGISTERED = 0;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_pw(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_store.sv
// DEPTH x DATAWIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_sync_store #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATAWIDTH-1:0] rdata
);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with fill count, programmable almost levels, sticky errors and flush.
// Optional high-water mark output peak_count is enabled by defining FIFO_WATERMARK_EN.
module fifo_sync_lvl
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int SHOW_AHEAD = MODE_SHOW_AHEAD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [DATAWIDTH-1:0]       data_in,
  input  logic                       rd,
  output logic [DATAWIDTH-1:0]       data_out,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic [fifo_cw(DEPTH)-1:0]  af_level,
  input  logic [fifo_cw(DEPTH)-1:0]  ae_level,
  output logic [fifo_cw(DEPTH)-1:0]  count,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_almost_full,
  output logic                       fifo_almost_empty,
  output logic                       fifo_overflow,
  output logic                       fifo_underflow
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [fifo_cw(DEPTH)-1:0]  peak_count
`endif
);

  localparam int CW = fifo_cw(DEPTH);
  localparam int PW = fifo_pw(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic                 full, empty, we, re;
  logic [DATAWIDTH-1:0] rd_data;

  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    we      = wr & ~full & ~flush;
    re      = rd & ~empty & ~flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (we) wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + PW'(1);
      if (re) rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + PW'(1);
      if (we & ~re)      count_d = count_q + CW'(1);
      else if (re & ~we) count_d = count_q - CW'(1);
    end
    // Setting wins over clr_err; a flush masks the request that would set the flag.
    ovf_d = (wr & full & ~flush)  | (ovf_q & ~clr_err);
    udf_d = (rd & empty & ~flush) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_sync_store #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .AW        (PW)
  ) u_store (
    .clk   (clk),
    .we    (we & ~reset),
    .waddr (wptr_q),
    .wdata (data_in),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  if (SHOW_AHEAD == MODE_SHOW_AHEAD) begin : g_show_ahead
    // Gated while empty so the unreset storage never leaks onto data_out.
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_registered
    logic [DATAWIDTH-1:0] dout_q, dout_d;
    always_comb dout_d = re ? rd_data : dout_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dout_q <= '0;
      else       dout_q <= dout_d;
    end
    assign data_out = dout_q;
  end

`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] peak_q, peak_d;
  always_comb begin
    peak_d = peak_q;
    if (clr_err || (count_d > peak_q)) peak_d = count_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end
  assign peak_count = peak_q;
`endif

  assign count             = count_q;
  assign fifo_full         = full;
  assign fifo_empty        = empty;
  assign fifo_almost_full  = (count_q >= af_level);
  assign fifo_almost_empty = (count_q <= ae_level);
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

endmodule
